// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: start/busy/done handshake, operands and HI/LO result bus.
// Ports: master drives start/op/a/b; slave drives busy/done/div_zero/hi/lo.
// WIDTH must match the muldiv_unit instance it is connected to.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU producing the HI/LO pair.
// Latency: done pulses WIDTH+1 cycles after start; divide-by-zero completes after 1 cycle.
// Backpressure: none; start is honoured only when idle, starts while busy are dropped.
// Ports: clock, reset (sync, active-high); bus (slave): start, op (funct[1:0]),
//        a, b in; busy, done, div_zero, hi, lo out (all registered).
// Build option: MULDIV_SIGNED_EN enables signed MULT/DIV with sign correction;
//        when undefined op[0] is ignored and every operation is unsigned.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               dz_q;       // pending divide-by-zero completion
  logic [WIDTH-1:0]   opnd_q;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc_q;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shl;
  logic               fits;
  logic [WIDTH-1:0]   rem_sub;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

`ifdef MULDIV_SIGNED_EN
  logic is_signed;
  logic a_neg;
  logic b_neg;
  logic neg_q;                    // negate product / quotient
  logic rneg_q;                   // negate remainder (dividend was negative)
`else
  logic op0_unused;
  assign op0_unused = bus.op[0];
`endif

  // Operand magnitudes. Held as unsigned WIDTH-bit values, which is the
  // WIDTH+1-bit signed magnitude with its always-zero top bit dropped, so the
  // most-negative operand maps to 2^(WIDTH-1) exactly.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    is_signed = ~bus.op[0];
    a_neg     = is_signed & bus.a[WIDTH-1];
    b_neg     = is_signed & bus.b[WIDTH-1];
    a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;
`else
    a_mag     = bus.a;
    b_mag     = bus.b;
`endif
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    shl     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    fits    = (shl >= {1'b0, opnd_q});
    // Only used when fits: true difference is below the divisor, so WIDTH bits suffice.
    rem_sub = shl[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      acc_d = fits ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                   : {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {add_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Final sign correction; pure pass-through for unsigned operations.
  always_comb begin
    fix_hi = acc_q[2*WIDTH-1:WIDTH];
    fix_lo = acc_q[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (!is_div_q) begin
      if (neg_q) {fix_hi, fix_lo} = -acc_q;
    end else begin
      if (neg_q)  fix_lo = -acc_q[WIDTH-1:0];
      if (rneg_q) fix_hi = -acc_q[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            is_div_q   <= bus.op[1];
            div_zero_q <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= CW'(WIDTH - 1);
`ifdef MULDIV_SIGNED_EN
            neg_q      <= a_neg ^ b_neg;
            rneg_q     <= a_neg;
`endif
            if (bus.op[1]) begin
              acc_q  <= {{WIDTH{1'b0}}, a_mag};
              opnd_q <= b_mag;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, b_mag};
              opnd_q <= a_mag;
            end
            // Divide by zero bypasses the iterations and completes on the
            // next edge; FIX sees dz_q and leaves hi/lo untouched.
            if (bus.op[1] && (bus.b == '0)) begin
              dz_q    <= 1'b1;
              state_q <= FIX;
            end else begin
              dz_q    <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
          if (dz_q) begin
            div_zero_q <= 1'b1;
          end else begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit (WIDTH = 32) with a
// cycle-level reference model checked every cycle plus literal result checks.
// Signed scenarios are compiled in only with MULDIV_SIGNED_EN.
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of one operation straight from integer arithmetic.
  function automatic void model_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic        sgn;
    logic [63:0] p;
    longint      sa, sb, q, r;
`ifdef MULDIV_SIGNED_EN
    sgn = ~op[0];
`else
    sgn = 1'b0;
`endif
    dz = 1'b0;
    hi = '0;
    lo = '0;
    if (!op[1]) begin
      if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else     p = {32'h0, a} * {32'h0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'h0) begin
      dz = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'h0, a});
        sb = longint'({32'h0, b});
      end
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  // Reference model: outputs as they must look after each rising edge.
  logic        m_busy = 0, m_done = 0, m_dz = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  int          m_left = 0;
  logic [31:0] p_hi, p_lo;
  logic        p_dz;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          if (p_dz) m_dz = 1;
          else begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end else if (bus.start) begin
        model_calc(bus.op, bus.a, bus.b, p_hi, p_lo, p_dz);
        m_dz   = 0;
        m_busy = 1;
        m_left = p_dz ? 1 : W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'h0, bus.busy}, {31'h0, m_busy});
      chk("cyc_done", {31'h0, bus.done}, {31'h0, m_done});
      chk("cyc_div_zero", {31'h0, bus.div_zero}, {31'h0, m_dz});
      chk("cyc_hi", bus.hi, m_hi);
      chk("cyc_lo", bus.lo, m_lo);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; start is sampled on the following edge (E0).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bsy);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    bsy = 0;
    forever begin
      if (bus.busy) bsy++;
      if (bus.done || lat >= 100) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz, input int exp_lat);
    int lat, bsy;
    run_op(op, a, b, lat, bsy);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_busy_cycles"}, bsy, exp_lat);
    chk({name, "_hi"}, bus.hi, exp_hi);
    chk({name, "_lo"}, bus.lo, exp_lo);
    chk({name, "_div_zero"}, {31'h0, bus.div_zero}, {31'h0, exp_dz});
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    repeat (3) tick();
    chk_en = 1;
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_div_zero", {31'h0, bus.div_zero}, 32'h0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    rst = 1'b0;
    tick();

    // Largest unsigned product.
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    tick();
    do_op("multu_carry", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, 1'b0, 33);
    tick();

`ifdef MULDIV_SIGNED_EN
    do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
    tick();
    do_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33);
    tick();
    do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    do_op("divu_b2b", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33);
    tick();
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
    tick();
`else
    // op[0] ignored: MULT/DIV behave as unsigned.
    do_op("mult_as_u", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 33);
    tick();
    do_op("div_as_u", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 33);
    do_op("divu_b2b", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33);
    tick();
    do_op("div_big_u", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33);
    tick();
`endif

    do_op("divu_by1", 2'b11, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0, 33);
    tick();
    do_op("divu_small", 2'b11, 32'd5, 32'd7, 32'd5, 32'd0, 1'b0, 33);
    tick();

    // Divide by zero keeps the preloaded HI/LO; next start clears the flag.
    do_op("preload", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33);
    tick();
    do_op("div_zero", 2'b10, 32'd5, 32'd0, 32'd0, 32'd6, 1'b1, 1);
    do_op("after_dz", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33);
    do_op("divu_b2b2", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    tick();

    // Ignored start while busy, then reset aborts the operation.
    dones = 0;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 5) begin
        bus.start = 1'b1;
        bus.a = 32'd3;
        bus.b = 32'd4;
      end else begin
        bus.start = 1'b0;
      end
      rst = (c == 10);
      tick();
      if (bus.done) dones++;
      if (c == 9) chk("busy_before_abort", {31'h0, bus.busy}, 32'h1);
      if (c == 10) begin
        chk("abort_busy", {31'h0, bus.busy}, 32'h0);
        chk("abort_hi", bus.hi, 32'h0);
        chk("abort_lo", bus.lo, 32'h0);
      end
    end
    chk("abort_no_done", dones, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    do_op("fresh", 2'b01, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 33);
    tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
